// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel.
// Tracks packet boundaries on the read side and flags end-of-packet and truncated packets.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int LEN_MSB   = 7,
  parameter int LEN_LSB   = 2,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              pkt_end,
  output logic              pkt_err,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count
);

  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int PCNT_W = (LEN_W + 1 < 7) ? 7 : LEN_W + 1;

  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   AF_LEVEL = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               pkt_end_q, pkt_end_d;
  logic               pkt_err_q, pkt_err_d;

  logic               flush;
  logic               wr_acc;
  logic               rd_acc;
  entry_t             rd_entry;
  logic [LEN_W-1:0]   rd_len;

  assign flush = ~resetn | soft_reset;

  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign almost_full = (count_q >= AF_LEVEL);
  assign count       = count_q;

  assign wr_acc   = write_enb & ~full & ~flush;
  assign rd_acc   = read_enb & ~empty;
  assign rd_entry = mem[rd_ptr_q[ADDR_W-1:0]];
  assign rd_len   = rd_entry.data[LEN_MSB:LEN_LSB];

  // NOTE: storage has no reset; only the pointers define what is valid,
  // which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= '{hdr: lfd_state, data: data_in};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pcnt_d       = pcnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_err_d    = 1'b0;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase

    if (rd_acc) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      data_out_d   = rd_entry.data;
      data_valid_d = 1'b1;
      if (rd_entry.hdr) begin
        // Header reload; a non-zero remainder means the previous packet was cut short.
        pcnt_d    = PCNT_W'(rd_len) + PCNT_ONE;
        pkt_err_d = (pcnt_q != '0);
      end else if (pcnt_q != '0) begin
        pcnt_d    = pcnt_q - PCNT_ONE;
        pkt_end_d = (pcnt_q == PCNT_ONE);
      end else begin
        pkt_err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pcnt_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pcnt_q       <= pcnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_end_q    <= pkt_end_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_err    = pkt_err_q;

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware synchronous FIFO for one router output channel.
- Sits between the router register/FSM stage and one output port.
- Each entry stores a header flag plus a data word. A read-side payload counter tracks packet boundaries.
- Adds features the previous generation lacks: occupancy count, almost-full flag, registered data-valid, end-of-packet strobe, and truncated-packet error detection.

Parameters:
- DATA_W, 8: data word width.
- DEPTH, 16: number of entries; must be a power of 2, at least 4.
- ADDR_W, 4: log2(DEPTH).
- LEN_MSB, 7: MSB of the length field in a header word.
- LEN_LSB, 2: LSB of the length field in a header word.
- AF_MARGIN, 2: almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- soft_reset  in  1  synchronous, active-high flush; identical effect to reset.
- write_enb  in  1  write request.
- lfd_state  in  1  1 = data_in is a packet header; stored as the entry flag.
- data_in  in  DATA_W  write data.
- read_enb  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out holds a word read in the previous cycle.
- pkt_end  out  1  data_out is the last word (parity) of a packet.
- pkt_err  out  1  pulse: a header was read while the previous packet was incomplete.
- full  out  1  DEPTH entries occupied.
- empty  out  1  zero entries occupied.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (DATA_W+1) array. Bit DATA_W holds lfd_state.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide, with the MSB used as the wrap bit.
  - full = (MSBs differ) and (low ADDR_W bits equal).
  - empty = (pointers equal).
  - full, empty, almost_full and count are combinational from registered pointers/count, so they reflect state after the last edge.
- Reset (resetn=0 or soft_reset=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0, payload counter=0.
  - data_out=0, data_valid=0, pkt_end=0, pkt_err=0.
  - Resulting flags: empty=1, full=0, almost_full=0.
  - Array contents are not cleared.
  - Reset has priority over any concurrent read or write. A packet in flight is discarded.
- Write accepted when write_enb=1 and full=0:
  - mem[wr_ptr low bits] <= {lfd_state, data_in}; wr_ptr increments and wraps naturally.
  - A write while full is dropped silently; no pointer change.
- Read accepted when read_enb=1 and empty=0:
  - data_out <= stored data; data_valid=1 on the next cycle (1-cycle latency); rd_ptr increments.
  - A read while empty is ignored: data_valid=0, data_out holds its last value.
  - Every cycle without an accepted read drives data_valid=0 and pkt_end=0. Never drive high-Z.
- Count:
  - +1 on accepted write only; -1 on accepted read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous read and write:
  - When full, the write is rejected even if a read occurs that cycle. The read proceeds, so count becomes DEPTH-1.
  - When empty, the read is rejected; the write proceeds, so count becomes 1.
  - Otherwise both are accepted.
- Payload counter (pcnt, 7 bits min, width LEN_MSB-LEN_LSB+2):
  - Accepted read of a header entry (flag=1): pcnt <= len+1, where len = word[LEN_MSB:LEN_LSB] and the +1 covers parity. If pcnt != 0 at that moment, pkt_err pulses high for 1 cycle, aligned with data_valid.
  - Accepted read of a non-header entry with pcnt > 0: pcnt <= pcnt-1. If pcnt was 1, pkt_end=1 alongside that word.
  - Accepted read of a non-header entry with pcnt = 0 (stray data): word is still delivered, pcnt stays 0, pkt_err pulses.
  - A header with len=0 loads pcnt=1; the next word read is flagged pkt_end.
- Pointer wrap: after DEPTH writes, wr_ptr low bits return to 0 and the MSB toggles. Ordering is preserved across any number of wraps.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_valid=0, data_out=0.
- Write header 0x0D (len=3) with lfd_state=1, then 0xA1, 0xA2, 0xA3, parity 0x5F; then read 5 consecutive cycles -> count 5→0; data_out 0x0D, A1, A2, A3, 5F, each 1 cycle after its read_enb; pkt_end=1 only with 0x5F; pkt_err=0.
- Write 16 words (DEPTH=16) -> full=1 and almost_full=1 (from count=14). 17th write is dropped. Simultaneous read+write while full -> count=15, and the next read returns word 2, not the dropped one.
- Fill/drain 40 words in mixed bursts, including simultaneous read/write at count=1 and count=15 -> output order equals input order across wraps; count always matches the model.
- Read 2 of 5 words of a 0x0D packet, then read a new header 0x09 -> pkt_err=1 for 1 cycle with header 0x09; pcnt reloads to 3.
- soft_reset=1 with count=7 mid-packet, plus concurrent write_enb and read_enb -> next cycle count=0, empty=1, data_valid=0; a following packet reads cleanly with pkt_err=0.
